// File: rtl/usb_tx_output_clock_gen.sv
// USB TX bit-strobe generator: emits a one-cycle bit_en_TX every BASE_PERIOD clocks, with every
// LONG_EVERY-th bit stretched by one clock (8, 8, 9 -> 12 Mbps from 100 MHz with defaults).
module usb_tx_output_clock_gen #(
   parameter int unsigned BASE_PERIOD = 8,
   parameter int unsigned LONG_EVERY  = 3
) (
   input  logic clk,
   input  logic n_rst,
   input  logic packet_load_complete_TX,
   output logic bit_en_TX
);

   localparam int unsigned CntW = $clog2(BASE_PERIOD + 1);
   localparam int unsigned PhW  = (LONG_EVERY > 1) ? $clog2(LONG_EVERY) : 1;

   localparam logic [CntW-1:0] ShortLast = CntW'(BASE_PERIOD - 1);
   localparam logic [CntW-1:0] LongLast  = CntW'(BASE_PERIOD);
   localparam logic [PhW-1:0]  PhaseLast = PhW'(LONG_EVERY - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [PhW-1:0]  phase_q, phase_d;
   logic [CntW-1:0] last_cnt;

   always_comb begin
      last_cnt  = (phase_q == PhaseLast) ? LongLast : ShortLast;
      // Gated by enable so a strobe in the cycle enable drops is suppressed.
      bit_en_TX = packet_load_complete_TX & ~n_rst & (cnt_q == last_cnt);
   end

   always_comb begin
      cnt_d   = '0;
      phase_d = '0;
      if (packet_load_complete_TX) begin
         if (bit_en_TX) begin
            cnt_d   = '0;
            phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PhW'(1);
         end else begin
            cnt_d   = cnt_q + CntW'(1);
            phase_d = phase_q;
         end
      end
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         cnt_q   <= '0;
         phase_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: tb/tb_usb_tx_output_clock_gen.sv
// Bench for usb_tx_output_clock_gen: directed scenarios with literal strobe positions, then
// randomized enable/reset traffic checked every cycle against a cumulative-target model.
module tb_usb_tx_output_clock_gen;

   localparam int unsigned BASE = 8;
   localparam int unsigned LE   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;
   logic bit_en_TX;

   int unsigned checks = 0;
   int unsigned errors = 0;

   usb_tx_output_clock_gen #(
      .BASE_PERIOD(BASE),
      .LONG_EVERY (LE)
   ) dut (
      .clk                    (clk),
      .n_rst                  (rst),
      .packet_load_complete_TX(en),
      .bit_en_TX              (bit_en_TX)
   );

   always #5 clk = ~clk;

   function automatic int unsigned period_of(input int unsigned idx);
      return BASE + (((idx % LE) == LE - 1) ? 1 : 0);
   endfunction

   // Model: strobe when the 1-based enable-high cycle number hits the running sum of periods.
   int unsigned elapsed = 0;
   int unsigned bit_idx = 0;
   int unsigned target  = (LE == 1) ? BASE + 1 : BASE;
   logic        exp_strobe;

   assign exp_strobe = en && !rst && ((elapsed + 1) == target);

   always @(posedge clk or posedge rst) begin
      if (rst || !en) begin
         elapsed <= 0;
         bit_idx <= 0;
         target  <= period_of(0);
      end else begin
         if ((elapsed + 1) == target) begin
            bit_idx <= bit_idx + 1;
            target  <= target + period_of(bit_idx + 1);
         end
         elapsed <= elapsed + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_list(input string name, input int exp[$], input int got[$]);
      check({name, " count"}, got.size(), exp.size());
      for (int k = 0; k < exp.size(); k++) begin
         check($sformatf("%s strobe%0d", name, k), (k < got.size()) ? got[k] : -1, exp[k]);
      end
   endtask

   // Per-cycle compare plus strobe-position recorders (1-based enable-high cycle numbers).
   int   run_cyc = 0;
   int   hits[$];
   int   mhits[$];
   logic prev_en_out = 1'b0;

   always @(negedge clk) begin
      if (en && !rst) run_cyc = run_cyc + 1;
      else            run_cyc = 0;
      if (bit_en_TX)  hits.push_back(run_cyc);
      if (exp_strobe) mhits.push_back(run_cyc);
      check("bit_en_TX", bit_en_TX, exp_strobe);
      check("no_back_to_back", prev_en_out && bit_en_TX, 1'b0);
      prev_en_out = bit_en_TX;
   end

   int e7[$] = '{8, 16, 25, 33, 41, 50, 58};
   int e3[$] = '{8, 16, 25};
   int e2[$] = '{8, 16};

   initial begin
      int unsigned r;

      // Reset held with enable high.
      repeat (10) @(posedge clk);
      #1;
      check("rst cnt", dut.cnt_q, 0);
      check("rst phase", dut.phase_q, 0);
      check("rst bit_en", bit_en_TX, 0);

      // Release with enable high, 60 cycles.
      @(posedge clk);
      #2;
      hits.delete();
      mhits.delete();
      rst = 1'b0;
      repeat (60) @(posedge clk);
      check_list("run60", e7, hits);
      check_list("model60", e7, mhits);

      // 5 high, 1 low, restart.
      #1 en = 1'b0;
      @(posedge clk);
      #1 en = 1'b1;
      repeat (5) @(posedge clk);
      #1 en = 1'b0;
      @(posedge clk);
      #1 en = 1'b1;
      hits.delete();
      mhits.delete();
      repeat (26) @(posedge clk);
      check_list("restart", e3, hits);
      check_list("model_restart", e3, mhits);

      // Drop enable in strobe cycle 25.
      #1 en = 1'b0;
      @(posedge clk);
      #1 en = 1'b1;
      hits.delete();
      repeat (24) @(posedge clk);
      #1;
      check("pre-drop cnt", dut.cnt_q, 8);
      check("pre-drop phase", dut.phase_q, 2);
      en = 1'b0;
      @(posedge clk);
      #1;
      check("drop cnt", dut.cnt_q, 0);
      check("drop phase", dut.phase_q, 0);
      check_list("drop25", e2, hits);

      // Idle for 100 cycles.
      hits.delete();
      repeat (100) @(posedge clk);
      check("idle strobes", hits.size(), 0);

      // Async reset at cycle 20, then resume.
      #1 en = 1'b1;
      repeat (19) @(posedge clk);
      #1;
      check("c20 cnt", dut.cnt_q, 3);
      check("c20 phase", dut.phase_q, 2);
      #1 rst = 1'b1;
      #1;
      check("async cnt", dut.cnt_q, 0);
      check("async phase", dut.phase_q, 0);
      check("async bit_en", bit_en_TX, 0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      hits.delete();
      mhits.delete();
      repeat (26) @(posedge clk);
      check_list("post_rst", e3, hits);
      check_list("model_post_rst", e3, mhits);

      // Random traffic with short async reset pulses.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (rst) rst = 1'b0;
         en = ($urandom_range(0, 99) < 97);
         r  = $urandom_range(0, 199);
         if (r < 3) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end else if (r < 5) begin
            #1 rst = 1'b1;
         end
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
